// File: rtl/sound_synth_mix.sv
// sound_synth_mix: NCH-channel tone synthesiser feeding one PWM audio pin.
// Each channel has a phase accumulator, a waveform select and a volume.
// Channels are mixed one per clock into a single duty value per carrier period.
//
// Ports:
//   CLK100MHZ      system clock
//   BTNC           synchronous active-high reset
//   SW[NCH]        per-channel enable, sampled at the sample tick
//   cfg_we         one-cycle write strobe for channel cfg_ch's shadow config
//   cfg_ch         channel being written
//   cfg_inc        phase increment per sample
//   cfg_vol        channel volume
//   cfg_mode       waveform: 0 square, 1 saw, 2 triangle, 3 silent
//   AUD_PWM        registered PWM output
//   sample_strobe  high on the cycle a new duty is loaded
module sound_synth_mix #(
  parameter int NCH     = 4,
  parameter int PHASE_W = 24,
  parameter int PWM_W   = 8,
  parameter int VOL_W   = 4
) (
  input  logic                                    CLK100MHZ,
  input  logic                                    BTNC,
  input  logic [NCH-1:0]                          SW,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [PHASE_W-1:0]                      cfg_inc,
  input  logic [VOL_W-1:0]                        cfg_vol,
  input  logic [1:0]                              cfg_mode,
  output logic                                    AUD_PWM,
  output logic                                    sample_strobe
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LOG_N  = $clog2(NCH);
  localparam int ACC_W  = PWM_W + LOG_N;
  localparam int PROD_W = PWM_W + VOL_W;

  localparam logic [PWM_W-1:0] CNT_MAX     = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] CNT_PRE_MAX = CNT_MAX - PWM_W'(1);
  localparam logic [PWM_W-1:0] MIX_FIRST   = PWM_W'(1);
  localparam logic [PWM_W-1:0] MIX_SECOND  = PWM_W'(2);
  localparam logic [PWM_W-1:0] MIX_LAST    = PWM_W'(NCH);
  localparam logic [PWM_W-1:0] DUTY_AT     = PWM_W'(NCH + 1);

  logic [PWM_W-1:0]   pwm_cnt_r;
  logic [PHASE_W-1:0] phase_r    [NCH];
  logic [PHASE_W-1:0] sh_inc_r   [NCH];
  logic [VOL_W-1:0]   sh_vol_r   [NCH];
  logic [1:0]         sh_mode_r  [NCH];
  logic [VOL_W-1:0]   act_vol_r  [NCH];
  logic [1:0]         act_mode_r [NCH];
  logic [NCH-1:0]     en_r;
  logic [ACC_W-1:0]   acc_r;
  logic [PWM_W-1:0]   duty_next_r;
  logic [PWM_W-1:0]   duty_r;
  logic               aud_pwm_r;
  logic               sample_strobe_r;

  logic [CH_W-1:0]    mix_ch_s;
  logic [PWM_W-1:0]   seg_s;
  logic [PWM_W-1:0]   wave_s;
  logic [PROD_W-1:0]  prod_s;
  logic [PWM_W-1:0]   level_s;

  assign AUD_PWM       = aud_pwm_r;
  assign sample_strobe = sample_strobe_r;

  // Scaled level of the channel being mixed this cycle (channel = pwm_cnt-1).
  always_comb begin
    mix_ch_s = CH_W'(pwm_cnt_r - PWM_W'(1));
    seg_s    = phase_r[mix_ch_s][PHASE_W-1 -: PWM_W];
    wave_s   = '0;
    if (en_r[mix_ch_s]) begin
      case (act_mode_r[mix_ch_s])
        2'd0:    wave_s = seg_s[PWM_W-1] ? {PWM_W{1'b1}} : {PWM_W{1'b0}};
        2'd1:    wave_s = seg_s;
        2'd2:    wave_s = seg_s[PWM_W-1] ? ~{seg_s[PWM_W-2:0], 1'b0}
                                         :  {seg_s[PWM_W-2:0], 1'b0};
        default: wave_s = '0;
      endcase
    end else begin
      wave_s = '0;
    end
    prod_s  = PROD_W'(wave_s) * PROD_W'(act_vol_r[mix_ch_s]);
    level_s = PWM_W'(prod_s >> VOL_W);
  end

  // Carrier counter, shadow/active config and per-channel phase at the tick.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      pwm_cnt_r <= '0;
      en_r      <= '0;
      for (int c = 0; c < NCH; c++) begin
        phase_r[c]    <= '0;
        sh_inc_r[c]   <= '0;
        sh_vol_r[c]   <= '0;
        sh_mode_r[c]  <= '0;
        act_vol_r[c]  <= '0;
        act_mode_r[c] <= '0;
      end
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
      if (pwm_cnt_r == '0) begin
        en_r <= SW;
      end
      for (int c = 0; c < NCH; c++) begin
        // The increment being made active is applied on this same tick, so
        // only the shadow copy needs to exist for it.
        if (pwm_cnt_r == '0) begin
          act_vol_r[c]  <= sh_vol_r[c];
          act_mode_r[c] <= sh_mode_r[c];
          phase_r[c]    <= SW[c] ? (phase_r[c] + sh_inc_r[c]) : '0;
        end
        // A write on the tick cycle lands in shadow after the copy above read it.
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          sh_inc_r[c]  <= cfg_inc;
          sh_vol_r[c]  <= cfg_vol;
          sh_mode_r[c] <= cfg_mode;
        end
      end
    end
  end

  // Sequential mixer, duty pipeline and registered PWM comparator.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      acc_r           <= '0;
      duty_next_r     <= '0;
      duty_r          <= '0;
      aud_pwm_r       <= 1'b0;
      sample_strobe_r <= 1'b0;
    end else begin
      if (pwm_cnt_r == MIX_FIRST) begin
        acc_r <= ACC_W'(level_s);
      end else if ((pwm_cnt_r >= MIX_SECOND) && (pwm_cnt_r <= MIX_LAST)) begin
        acc_r <= acc_r + ACC_W'(level_s);
      end
      if (pwm_cnt_r == DUTY_AT) begin
        duty_next_r <= PWM_W'(acc_r >> LOG_N);
      end
      if (pwm_cnt_r == CNT_MAX) begin
        duty_r <= duty_next_r;
      end
      // Raised one cycle early so the pulse coincides with the duty load cycle.
      sample_strobe_r <= (pwm_cnt_r == CNT_PRE_MAX);
      aud_pwm_r       <= (pwm_cnt_r < duty_r);
    end
  end

endmodule

// File: tb/tb_sound_synth_mix.sv
// Self-checking bench for sound_synth_mix with default parameters.
// A sample-level model computes each period's duty straight from the
// waveform/volume arithmetic; a compare process checks AUD_PWM and
// sample_strobe every cycle, and directed scenarios pin literal duties.
module tb_sound_synth_mix;
  localparam int NCH    = 4;
  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       btnc;
  logic [3:0] sw;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [23:0] cfg_inc;
  logic [3:0] cfg_vol;
  logic [1:0] cfg_mode;
  logic       aud;
  logic       strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_synth_mix #(.NCH(4), .PHASE_W(24), .PWM_W(8), .VOL_W(4)) dut (
    .CLK100MHZ(clk), .BTNC(btnc), .SW(sw), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_vol(cfg_vol), .cfg_mode(cfg_mode),
    .AUD_PWM(aud), .sample_strobe(strobe)
  );

  // ---------------- reference model ----------------
  int          m_cnt = 0;
  int          m_duty = 0;
  int          m_sample = 0;
  logic        m_aud = 1'b0;
  bit          m_valid = 1'b0;
  logic [23:0] m_phase [NCH];
  logic [23:0] m_inc   [NCH];
  int          m_vol   [NCH];
  int          m_mode  [NCH];

  function automatic int wave_of(input logic [23:0] ph, input int mode);
    int s;
    s = int'(ph[23:16]);
    case (mode)
      0:       return (s >= 128) ? 255 : 0;
      1:       return s;
      2:       return (s < 128) ? 2 * s : 511 - 2 * s;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int sum;
    if (btnc) begin
      m_valid = 1'b1;
      m_cnt = 0; m_duty = 0; m_sample = 0; m_aud = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_phase[c] = '0; m_inc[c] = '0; m_vol[c] = 0; m_mode[c] = 0;
      end
    end else begin
      m_aud = (m_cnt < m_duty);
      if (m_cnt == PERIOD - 1) m_duty = m_sample;
      if (m_cnt == 0) begin
        sum = 0;
        for (int c = 0; c < NCH; c++) begin
          if (sw[c]) begin
            m_phase[c] = m_phase[c] + m_inc[c];
            sum += (wave_of(m_phase[c], m_mode[c]) * m_vol[c]) / 16;
          end else begin
            m_phase[c] = '0;
          end
        end
        m_sample = sum / NCH;
      end
      if (cfg_we) begin
        m_inc[cfg_ch]  = cfg_inc;
        m_vol[cfg_ch]  = int'(cfg_vol);
        m_mode[cfg_ch] = int'(cfg_mode);
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk_bit("aud_pwm", aud, m_aud);
      chk_bit("sample_strobe", strobe, m_cnt == PERIOD - 1);
    end
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (m_cnt == v) break;
    end
    if (m_cnt != v) begin
      checks++; errors++;
      $display("FAIL wait_cnt timeout waiting for %0d", v);
    end
  endtask

  // High cycles of AUD_PWM over one period, counted from pwm_cnt==1.
  task automatic measure(output int h);
    wait_cnt(1);
    h = int'(aud);
    repeat (PERIOD - 1) begin
      @(negedge clk);
      h += int'(aud);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    btnc = 1'b1;
    repeat (2) @(negedge clk);
    btnc = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input logic [23:0] inc, input int vol, input int mode);
    @(negedge clk);
    cfg_ch = 2'(ch); cfg_inc = inc; cfg_vol = 4'(vol); cfg_mode = 2'(mode);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h;
    int hs [24];
    bit found;
    btnc = 1'b1; sw = 4'h0; cfg_we = 1'b0; cfg_ch = 2'd0;
    cfg_inc = 24'd0; cfg_vol = 4'd0; cfg_mode = 2'd0;

    // Reset held from power-up, then idle periods.
    repeat (5) begin
      @(negedge clk);
      chk_bit("reset_aud", aud, 1'b0);
      chk_bit("reset_strobe", strobe, 1'b0);
    end
    btnc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      measure(h);
      chk("idle_duty", h, 0);
    end

    // Square on ch0 alone: duty alternates 59 / 0.
    do_reset();
    cfg_write(0, 24'h800000, 15, 0);
    sw = 4'b0001;
    measure(h); measure(h);
    for (int i = 0; i < 4; i++) measure(hs[i]);
    for (int i = 0; i < 3; i++) begin
      chk("square_pair_sum", hs[i] + hs[i+1], 59);
      chk("square_level", int'(hs[i] == 0 || hs[i] == 59), 1);
    end

    // Saw on ch1: duty = n>>3 over consecutive samples n.
    do_reset();
    cfg_write(1, 24'h010000, 8, 1);
    sw = 4'b0010;
    measure(h); measure(h);
    for (int i = 0; i < 24; i++) measure(hs[i]);
    chk("saw_start_small", int'(hs[0] <= 8), 1);
    for (int i = 0; i < 23; i++) chk("saw_step", int'((hs[i+1] - hs[i]) inside {0, 1}), 1);
    for (int i = 0; i < 16; i++) chk("saw_eight_run", hs[i+8], hs[i] + 1);

    // Full mix, then drop channel 3 just before a high tick.
    do_reset();
    for (int c = 0; c < NCH; c++) cfg_write(c, 24'h800000, 15, 0);
    sw = 4'hF;
    measure(h); measure(h);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      measure(h);
      chk("mix_level", int'(h == 0 || h == 239), 1);
      if (h == 239) begin
        found = 1'b1;
        break;
      end
    end
    sw = 4'h7;
    chk("mix_found_239", int'(found), 1);
    measure(h);
    chk("mix_low_after", h, 0);
    measure(h);
    chk("mix_three_ch", h, 179);

    // Mid-period volume write takes effect only after the next tick.
    do_reset();
    cfg_write(0, 24'h800000, 15, 0);
    sw = 4'b0001;
    measure(h); measure(h);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      measure(h);
      if (h == 59) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_found_59", int'(found), 1);
    wait_cnt(99);
    cfg_write(0, 24'h800000, 0, 0);
    measure(h); chk("mid_next_unchanged", h, 59);
    measure(h); chk("mid_after_tick", h, 0);
    measure(h); chk("mid_stays_zero", h, 0);

    // Reset at pwm_cnt==3 during a high period of a full mix.
    do_reset();
    for (int c = 0; c < NCH; c++) cfg_write(c, 24'h800000, 15, 0);
    sw = 4'hF;
    measure(h); measure(h);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      measure(h);
      if (h == 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_found_0", int'(found), 1);
    wait_cnt(3);
    chk_bit("rstmid_pre_high", aud, 1'b1);
    btnc = 1'b1;
    @(negedge clk);
    chk_bit("rstmid_aud", aud, 1'b0);
    btnc = 1'b0;
    measure(h); chk("rstmid_cleared_a", h, 0);
    measure(h); chk("rstmid_cleared_b", h, 0);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    sw = 4'hF;
    for (int cyc = 0; cyc < 30 * PERIOD; cyc++) begin
      @(negedge clk);
      cfg_we   = ($urandom_range(0, 23) == 0);
      cfg_ch   = 2'($urandom);
      cfg_inc  = 24'($urandom);
      cfg_vol  = 4'($urandom);
      cfg_mode = 2'($urandom);
      if ($urandom_range(0, 399) == 0) sw = 4'($urandom);
      btnc = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    btnc = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_synth_mix.md
# sound_synth_mix

Parametrised multi-channel tone synthesiser driving the board's single-bit audio PWM pin. It succeeds the single-tone sound block: NCH independent channels, each with a phase-accumulator oscillator, a selectable waveform and a 4-bit volume. Channels are mixed sequentially into one duty value per PWM carrier period. It sits directly between the board switches/config bus and AUD_PWM.

## Interface
- NCH, 4: channel count; power of two, 1..8
- PHASE_W, 24: phase accumulator width
- PWM_W, 8: PWM carrier/sample resolution; carrier period 2^PWM_W clocks; NCH+2 < 2^PWM_W
- VOL_W, 4: volume width
- CLK100MHZ  in  1  system clock, 100 MHz
- BTNC  in  1  reset, synchronous, active-high
- SW  in  NCH  per-channel enable
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  $clog2(NCH) (min 1)  channel to write
- cfg_inc  in  PHASE_W  phase increment per sample
- cfg_vol  in  VOL_W  volume
- cfg_mode  in  2  waveform: 0 square, 1 saw, 2 triangle, 3 silent
- AUD_PWM  out  1  registered PWM audio output
- sample_strobe  out  1  one-cycle pulse when a new duty is loaded

## Operation
- Single clock; one synchronous active-high reset on BTNC.
- pwm_cnt: free-running PWM_W-bit counter, wraps 2^PWM_W-1 -> 0.
- Config: cfg_we writes the shadow regs {inc, vol, mode} of channel cfg_ch. The shadow regs copy into the active regs when pwm_cnt==0, so a write takes effect at the next sample tick. A write on the same cycle as pwm_cnt==0 is shadowed but not used until the following tick.
- Sample tick (pwm_cnt==0): for each channel with SW[c]=1, phase[c] += inc (mod 2^PHASE_W). For each channel with SW[c]=0, phase[c] <= 0.
- Waveform, with s = phase[PHASE_W-1 -: PWM_W]:
  - square = s[MSB] ? all-ones : 0
  - saw = s
  - triangle = s[MSB] ? ~(s<<1) : (s<<1), PWM_W bits
  - silent = 0
  - A disabled channel yields 0.
- Scale: v[c] = (wave*vol) >> VOL_W, computed at full product width; the result fits PWM_W bits.
- Mixer, sequential: at pwm_cnt==1 the accumulator clears and adds v[0]. At pwm_cnt==k (k=2..NCH) it adds v[k-1]. At pwm_cnt==NCH+1, duty_next <= acc >> log2(NCH). The accumulator is PWM_W+log2(NCH) bits wide, so there is no overflow.
- At pwm_cnt==2^PWM_W-1, duty <= duty_next and sample_strobe=1 on that cycle.
- Output: AUD_PWM <= (pwm_cnt < duty), registered. duty=0 gives constant low. Max duty 2^PWM_W-1 gives high for all but one cycle per period.

## Timing
- Reset values: pwm_cnt 0, all phases 0, shadow/active inc 0, vol 0, mode 0, duty 0, duty_next 0, acc 0, AUD_PWM 0, sample_strobe 0.
- BTNC high on any cycle (mid-mix, mid-period): every register takes its reset value on the next edge. AUD_PWM is 0 the cycle after reset is sampled.
- Sample rate = 100e6 / 2^PWM_W, which is 390625 Hz by default. Tone frequency = inc * sample rate / 2^PHASE_W.
- Latency, config write to PWM change: the write is picked up at the next pwm_cnt==0. Its duty loads at that period's pwm_cnt==2^PWM_W-1. It appears on AUD_PWM one cycle after the next wrap.
- SW change is sampled only at pwm_cnt==0. SW toggling between ticks has no effect until the next tick.
- Simultaneous cfg_we and the shadow-to-active copy on the same cycle: the copy uses the old shadow value, and the new value is stored.

## Test plan
All scenarios use default parameters.
- Reset: hold BTNC 5 cycles from power-up X -> AUD_PWM=0 and sample_strobe=0 throughout. Release and run 3 periods with cfg untouched -> AUD_PWM stays 0.
- Square: ch0 inc=2^23, vol=15, mode 0, SW=4'b0001.
  - Duty alternates 59 and 0 per period, since (255*15)>>4=239 and 239>>2=59.
  - AUD_PWM is high exactly 59 cycles in alternate periods.
- Saw: ch1 inc=2^16, vol=8, mode 1, SW=4'b0010 -> duty at sample n is ((n*8)>>4)>>2 = n>>3, i.e. 0,0,...,1. The sequence wraps after 256 samples.
- Full mix: all four channels square, inc=2^23, vol=15, SW=4'hF -> duty alternates 239 and 0.
  - Clear SW[3] -> the next tick resets phase[3] and duty becomes 179 (717>>2).
- Mid-period config: write ch0 vol=0 at pwm_cnt=100 -> the current and next duty are unchanged. The duty of the sample after the next tick is 0.
- Reset mid-operation: assert BTNC at pwm_cnt=3 during a full mix -> next cycle AUD_PWM=0, pwm_cnt=0, phases 0, cfg cleared. After release the output stays 0 until reconfigured.
